// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-way round-robin arbiter and command sequencer in front of a single-port
// RAM. Each whole-byte request from m0/m1 becomes a two-beat command on
// ram_din/ram_rx_valid. For a read, the reply on ram_dout/ram_tx_valid is
// captured, or the read is aborted after TIMEOUT idle wait cycles.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_*/m1_*                request, write enable, address, write data
//   gnt[1:0]                 one-hot owner, held from CMD1 through DONE
//   done[1:0]                one-cycle completion pulse to the owner
//   rdata, err               read result and timeout flag, qualified by done
//   ram_din, ram_rx_valid    RAM command word {opcode[1:0], payload} and strobe
//   ram_dout, ram_tx_valid   RAM read data and its valid strobe
// All outputs are registered.
module ram_port_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_req,
   input  logic                 m0_we,
   input  logic [ADDR_SIZE-1:0] m0_addr,
   input  logic [ADDR_SIZE-1:0] m0_wdata,
   input  logic                 m1_req,
   input  logic                 m1_we,
   input  logic [ADDR_SIZE-1:0] m1_addr,
   input  logic [ADDR_SIZE-1:0] m1_wdata,
   output logic [1:0]           gnt,
   output logic [1:0]           done,
   output logic [ADDR_SIZE-1:0] rdata,
   output logic                 err,
   output logic [ADDR_SIZE+1:0] ram_din,
   output logic                 ram_rx_valid,
   input  logic [ADDR_SIZE-1:0] ram_dout,
   input  logic                 ram_tx_valid
);

   // The counter only has to reach TIMEOUT-1; the TIMEOUT-th idle cycle ends the wait.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD1  = 3'd1,
      CMD2  = 3'd2,
      RWAIT = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                 state_r;
   logic [CW-1:0]          cnt_r;
   logic                   last_r;     // 1 = m1 was granted last
   logic                   we_r;
   logic [ADDR_SIZE-1:0]   addr_r;
   logic [ADDR_SIZE-1:0]   wdata_r;

   logic                   any_req_s;
   logic                   win_m1_s;
   logic                   sel_we_s;
   logic [ADDR_SIZE-1:0]   sel_addr_s;
   logic [ADDR_SIZE-1:0]   sel_wdata_s;

   // Round-robin winner selection and field mux for the IDLE sample.
   always_comb begin
      any_req_s = m0_req | m1_req;
      win_m1_s  = 1'b0;
      if (m0_req && m1_req) begin
         win_m1_s = ~last_r;
      end else if (m1_req) begin
         win_m1_s = 1'b1;
      end else begin
         win_m1_s = 1'b0;
      end
      if (win_m1_s) begin
         sel_we_s    = m1_we;
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
      end
   end

   // Sequencer FSM; every output is set on the edge that enters its state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= {CW{1'b0}};
         last_r       <= 1'b1;
         we_r         <= 1'b0;
         addr_r       <= {ADDR_SIZE{1'b0}};
         wdata_r      <= {ADDR_SIZE{1'b0}};
         gnt          <= 2'b00;
         done         <= 2'b00;
         rdata        <= {ADDR_SIZE{1'b0}};
         err          <= 1'b0;
         ram_din      <= {(ADDR_SIZE+2){1'b0}};
         ram_rx_valid <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 2'b00;
               if (any_req_s) begin
                  we_r         <= sel_we_s;
                  addr_r       <= sel_addr_s;
                  wdata_r      <= sel_wdata_s;
                  gnt          <= win_m1_s ? 2'b10 : 2'b01;
                  ram_din      <= {(sel_we_s ? 2'b00 : 2'b10), sel_addr_s};
                  ram_rx_valid <= 1'b1;
                  state_r      <= CMD1;
               end else begin
                  ram_din      <= {(ADDR_SIZE+2){1'b0}};
                  ram_rx_valid <= 1'b0;
               end
            end
            CMD1: begin
               ram_din      <= {(we_r ? 2'b01 : 2'b11), (we_r ? wdata_r : {ADDR_SIZE{1'b0}})};
               ram_rx_valid <= 1'b1;
               state_r      <= CMD2;
            end
            CMD2: begin
               ram_din      <= {(ADDR_SIZE+2){1'b0}};
               ram_rx_valid <= 1'b0;
               if (we_r) begin
                  done    <= gnt;
                  err     <= 1'b0;
                  state_r <= DONE;
               end else begin
                  cnt_r   <= {CW{1'b0}};
                  state_r <= RWAIT;
               end
            end
            RWAIT: begin
               // A reply in the last allowed cycle still wins over the timeout.
               if (ram_tx_valid) begin
                  rdata   <= ram_dout;
                  err     <= 1'b0;
                  done    <= gnt;
                  state_r <= DONE;
               end else if (cnt_r == CNT_LAST) begin
                  rdata   <= {ADDR_SIZE{1'b0}};
                  err     <= 1'b1;
                  done    <= gnt;
                  state_r <= DONE;
               end else begin
                  cnt_r   <= cnt_r + CW'(1);
               end
            end
            DONE: begin
               done    <= 2'b00;
               gnt     <= 2'b00;
               last_r  <= gnt[1];
               state_r <= IDLE;
            end
            default: begin
               done         <= 2'b00;
               gnt          <= 2'b00;
               ram_din      <= {(ADDR_SIZE+2){1'b0}};
               ram_rx_valid <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Sequencing controller and two-way round-robin arbiter in front of the single-port RAM. Accepts whole-byte read/write transactions from two requesters (m0, m1). Converts each into the RAM's two-beat 10-bit command protocol on `ram_din`/`ram_rx_valid`. For reads, it captures `ram_dout` on `ram_tx_valid` and returns the byte with a one-cycle completion pulse.

## Interface
- `ADDR_SIZE`, default 8: RAM address and data width. The RAM command word is `ADDR_SIZE+2` bits wide.
- `TIMEOUT`, default 15: maximum number of RWAIT cycles allowed for `ram_tx_valid` before the read is aborted with an error.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1 each: transaction request. Hold high, with the fields stable, until the matching `done` bit.
- `m0_we`, `m1_we`  in  1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_SIZE each: byte address.
- `m0_wdata`, `m1_wdata`  in  ADDR_SIZE each: write data. Ignored on reads.
- `gnt`  out  2: one-hot owner of the current transaction. Held from CMD1 through DONE.
- `done`  out  2: one-cycle completion pulse to the owner.
- `rdata`  out  ADDR_SIZE: read result. Valid when `done` is high; holds its value until the next completion.
- `err`  out  1: qualifies `done`. 1 = read timed out.
- `ram_din`  out  ADDR_SIZE+2: RAM command word. [9:8] is the opcode, [7:0] is the payload.
- `ram_rx_valid`  out  1: command strobe.
- `ram_dout`  in  ADDR_SIZE: RAM read data.
- `ram_tx_valid`  in  1: RAM read-data valid.

## Operation
- RAM opcodes:
  - 00 = latch write address.
  - 01 = write payload to the latched write address.
  - 10 = latch read address.
  - 11 = read request. The RAM answers with `ram_tx_valid` and `ram_dout`; nominal latency is one cycle after the strobe.
- FSM states: IDLE, CMD1, CMD2, RWAIT, DONE.
- IDLE: if any req is high, select the winner, latch its we/addr/wdata, register `gnt`, and go to CMD1. Otherwise stay in IDLE.
- Arbitration: round-robin with a 1-bit last-grant pointer.
  - If only one requester is asking, it wins.
  - If both are asking, the requester that was not granted last wins.
  - The pointer updates in DONE. After reset the pointer favours m0.
- CMD1: `ram_rx_valid`=1 and `ram_din` = {we ? 00 : 10, addr}. Go to CMD2.
- CMD2: `ram_rx_valid`=1 and `ram_din` = {we ? 01 : 11, we ? wdata : 0}. A write goes to DONE; a read goes to RWAIT and clears the timeout counter.
- RWAIT:
  - `ram_rx_valid`=0.
  - If `ram_tx_valid`=1, register `ram_dout` into `rdata`, set `err`=0, and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set `rdata`=0 and `err`=1, and go to DONE.
- DONE: `done[owner]`=1 for exactly one cycle. A write sets `err`=0. Then go to IDLE and clear `gnt`.
- Req handling:
  - Req is sampled only in IDLE. Changes to any req or field between CMD1 and DONE have no effect.
  - If req is still high in the IDLE cycle after DONE, it is a new transaction.
- `ram_tx_valid` outside RWAIT is ignored.
- `ram_din`=0 and `ram_rx_valid`=0 in IDLE, RWAIT and DONE.

## Timing
- Reset, asynchronous and immediate: state=IDLE, `gnt`=0, `done`=0, `rdata`=0, `err`=0, `ram_din`=0, `ram_rx_valid`=0, pointer favours m0, counter=0.
- Reset mid-transaction aborts the transaction with no `done` pulse. The requester must reissue.
- Outputs are registered (Moore). No combinational path from any input to any output.
- Write: req sampled at edge E. CMD1 in cycle E+1, CMD2 in E+2, `done` in E+3. The next grant is sampled no earlier than the edge ending the IDLE cycle at E+4.
- Read with a 1-cycle RAM: CMD1 in E+1, CMD2 in E+2, `ram_tx_valid` in E+3 (RWAIT), `done`/`rdata` in E+4.
- Read with an n-cycle RAM latency: `done` in E+3+n, for n ≤ TIMEOUT.
- Read timeout: `done` with `err`=1 follows TIMEOUT consecutive RWAIT cycles with no `ram_tx_valid`.
- Sustained back-to-back load: one write per 4 cycles, one read per 5 cycles.

## Test plan
- Reset: assert `rst` mid-simulation, asynchronously to `clk` → all outputs 0 immediately, `gnt`=00.
- m0 write addr 0x3A, data 0x5C → `ram_din`=0x03A then 0x15C, `ram_rx_valid` high for 2 cycles, `done`=01 at E+3, `err`=0.
- m1 read addr 0x3A against a RAM model holding 0x5C → `ram_din`=0x23A then 0x300, `done`=10 at E+4, `rdata`=0x5C, `err`=0.
- m0 and m1 both requesting continuously after reset → grants alternate m0, m1, m0, m1. No grant overlaps. Each `done` pulse goes only to the current `gnt` owner.
- Read with a RAM stub that never asserts `ram_tx_valid`, TIMEOUT=15 → `done` pulses after 15 RWAIT cycles with `err`=1, `rdata`=0x00. The next transaction proceeds normally.
- Assert `rst` during CMD2 of an m0 write → no `done` pulse, `ram_rx_valid` drops immediately. After release, a pending m1 request is granted normally and m0 keeps priority on a tie.
